// File: rtl/id_stage_hazard.sv
// id_stage_hazard: instruction-decode stage for the LEGv8 subset.
// Decodes the IF/ID instruction, reads the register file, detects load-use
// and branch-operand hazards, resolves CBZ/CBNZ/B/BL/BR in ID and loads the
// registered ID/EX pipeline register one cycle later.
// Optional build macro ID_BL_LINK_EN: when defined, BL writes PC+4 to X30
// through idex_link; when undefined, BL behaves as B and idex_link is 0.
module id_stage_hazard #(
   parameter int XLEN  = 64,
   parameter int NREGS = 32,
   parameter int RA_W  = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_valid,
   input  logic [31:0]       if_instr,
   input  logic [XLEN-1:0]   if_pc,
   input  logic              wb_we,
   input  logic [RA_W-1:0]   wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              ex_mem_read,
   input  logic              ex_reg_write,
   input  logic [RA_W-1:0]   ex_rd,
   input  logic              mem_mem_read,
   input  logic [RA_W-1:0]   mem_rd,
   output logic              stall,
   output logic              flush,
   output logic [XLEN-1:0]   branch_target,
   output logic              idex_valid,
   output logic              idex_reg_write,
   output logic              idex_mem_read,
   output logic              idex_mem_write,
   output logic              idex_mem_to_reg,
   output logic              idex_alu_src,
   output logic [1:0]        idex_alu_op,
   output logic [RA_W-1:0]   idex_rs1,
   output logic [RA_W-1:0]   idex_rs2,
   output logic [RA_W-1:0]   idex_rd,
   output logic [XLEN-1:0]   idex_rdata1,
   output logic [XLEN-1:0]   idex_rdata2,
   output logic [XLEN-1:0]   idex_imm,
   output logic [XLEN-1:0]   idex_link
);

   localparam logic [RA_W-1:0] XZR      = RA_W'(NREGS - 1);
   localparam logic [RA_W-1:0] LINK_REG = RA_W'(30);

`ifdef ID_BL_LINK_EN
   localparam logic LINK_EN = 1'b1;
`else
   localparam logic LINK_EN = 1'b0;
`endif

   // D-type offset [20:12], sign-extended.
   function automatic logic signed [XLEN-1:0] sext_d(input logic [8:0] f);
      return XLEN'(signed'(f));
   endfunction

   // CB offset [23:5], word-scaled and sign-extended.
   function automatic logic signed [XLEN-1:0] sext_cb(input logic [18:0] f);
      return XLEN'(signed'({f, 2'b00}));
   endfunction

   // B/BL offset [25:0], word-scaled and sign-extended.
   function automatic logic signed [XLEN-1:0] sext_b(input logic [25:0] f);
      return XLEN'(signed'({f, 2'b00}));
   endfunction

   logic [XLEN-1:0] regs [NREGS];

   logic [10:0]            op;
   logic                   is_r, is_ldur, is_stur, is_cbz, is_cbnz, is_cb;
   logic                   is_b, is_bl, is_br, bl_link;
   logic [RA_W-1:0]        rs1_p0, rs2_p0, rd_p0, br_opnd;
   logic                   use_rs1, use_rs2;
   logic [XLEN-1:0]        rdata1_p0, rdata2_p0;
   logic signed [XLEN-1:0] imm_p0;
   logic                   load_use, br_hazard, stall_p0, taken, bubble;

   logic                   c_valid, c_reg_write, c_mem_read, c_mem_write;
   logic                   c_mem_to_reg, c_alu_src;
   logic [1:0]             c_alu_op;
   logic [RA_W-1:0]        c_rd;

   assign op      = if_instr[31:21];
   assign is_r    = (op == 11'b10001011000) || (op == 11'b11001011000) ||
                    (op == 11'b10001010000) || (op == 11'b10101010000);
   assign is_ldur = (op == 11'b11111000010);
   assign is_stur = (op == 11'b11111000000);
   assign is_cbz  = (op[10:3] == 8'b10110100);
   assign is_cbnz = (op[10:3] == 8'b10110101);
   assign is_cb   = is_cbz || is_cbnz;
   assign is_b    = (op[10:5] == 6'b000101);
   assign is_bl   = (op[10:5] == 6'b100101);
   assign is_br   = (op == 11'b11010110000);
   assign bl_link = is_bl && LINK_EN;

   // Second read port takes Rt for stores and compare-branches, Rm otherwise.
   assign rs1_p0  = if_instr[5 +: RA_W];
   assign rs2_p0  = (is_stur || is_cb) ? if_instr[0 +: RA_W] : if_instr[16 +: RA_W];
   assign rd_p0   = if_instr[0 +: RA_W];
   assign use_rs1 = is_r || is_ldur || is_stur || is_br;
   assign use_rs2 = is_r || is_stur || is_cb;

   // XZR is checked before the write-back bypass so a write to it never leaks.
   assign rdata1_p0 = (rs1_p0 == XZR) ? '0 :
                      (wb_we && wb_rd == rs1_p0) ? wb_data : regs[rs1_p0];
   assign rdata2_p0 = (rs2_p0 == XZR) ? '0 :
                      (wb_we && wb_rd == rs2_p0) ? wb_data : regs[rs2_p0];

   // Select the sign-extended immediate for the decoded format.
   always_comb begin
      imm_p0 = '0;
      if (is_ldur || is_stur)
         imm_p0 = sext_d(if_instr[20:12]);
      else if (is_cb)
         imm_p0 = sext_cb(if_instr[23:5]);
      else if (is_b || is_bl)
         imm_p0 = sext_b(if_instr[25:0]);
   end

   assign load_use  = ex_mem_read &&
                      ((use_rs1 && rs1_p0 != XZR && ex_rd == rs1_p0) ||
                       (use_rs2 && rs2_p0 != XZR && ex_rd == rs2_p0));
   assign br_opnd   = is_cb ? rs2_p0 : rs1_p0;
   assign br_hazard = (is_cb || is_br) && (br_opnd != XZR) &&
                      ((ex_reg_write && ex_rd == br_opnd) ||
                       (mem_mem_read && mem_rd == br_opnd));

   // Reset masks the combinational outputs so inputs are ignored while held.
   assign stall_p0 = reset && if_valid && (load_use || br_hazard);
   assign taken    = reset && if_valid && !stall_p0 &&
                     (is_b || is_bl || is_br ||
                      (is_cbz && rdata2_p0 == '0) || (is_cbnz && rdata2_p0 != '0));
   assign bubble   = !if_valid || stall_p0;

   assign stall         = stall_p0;
   assign flush         = taken;
   assign branch_target = is_br ? rdata1_p0 : (if_pc + $unsigned(imm_p0));

   // Control word for ID/EX: bubble on stall or empty slot, branches carry only link controls.
   always_comb begin
      c_valid      = 1'b0;
      c_reg_write  = 1'b0;
      c_mem_read   = 1'b0;
      c_mem_write  = 1'b0;
      c_mem_to_reg = 1'b0;
      c_alu_src    = 1'b0;
      c_alu_op     = 2'b00;
      c_rd         = rd_p0;
      if (!bubble) begin
         c_valid = 1'b1;
         if (is_r) begin
            c_reg_write = 1'b1;
            c_alu_op    = 2'b10;
         end else if (is_ldur) begin
            c_reg_write  = 1'b1;
            c_mem_read   = 1'b1;
            c_mem_to_reg = 1'b1;
            c_alu_src    = 1'b1;
         end else if (is_stur) begin
            c_mem_write = 1'b1;
            c_alu_src   = 1'b1;
         end else if (bl_link) begin
            c_reg_write = 1'b1;
            c_alu_op    = 2'b01;
            c_rd        = LINK_REG;
         end
      end
   end

   // Register file: writes to XZR are dropped, reset clears every entry.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (wb_we && wb_rd != XZR) begin
         regs[wb_rd] <= wb_data;
      end
   end

   // ---- ID -> EX boundary ----
   // ID/EX register: a bubble zeroes the whole slot.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         idex_valid      <= 1'b0;
         idex_reg_write  <= 1'b0;
         idex_mem_read   <= 1'b0;
         idex_mem_write  <= 1'b0;
         idex_mem_to_reg <= 1'b0;
         idex_alu_src    <= 1'b0;
         idex_alu_op     <= 2'b00;
         idex_rs1        <= '0;
         idex_rs2        <= '0;
         idex_rd         <= '0;
         idex_rdata1     <= '0;
         idex_rdata2     <= '0;
         idex_imm        <= '0;
      end else begin
         idex_valid      <= c_valid;
         idex_reg_write  <= c_reg_write;
         idex_mem_read   <= c_mem_read;
         idex_mem_write  <= c_mem_write;
         idex_mem_to_reg <= c_mem_to_reg;
         idex_alu_src    <= c_alu_src;
         idex_alu_op     <= c_alu_op;
         idex_rs1        <= bubble ? '0 : rs1_p0;
         idex_rs2        <= bubble ? '0 : rs2_p0;
         idex_rd         <= bubble ? '0 : c_rd;
         idex_rdata1     <= bubble ? '0 : rdata1_p0;
         idex_rdata2     <= bubble ? '0 : rdata2_p0;
         idex_imm        <= bubble ? '0 : $unsigned(imm_p0);
      end
   end

`ifdef ID_BL_LINK_EN
   // Return address travels with BL so EX can forward it to write-back.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         idex_link <= '0;
      else
         idex_link <= (!bubble && is_bl) ? (if_pc + XLEN'(4)) : '0;
   end
`else
   assign idex_link = '0;
`endif

endmodule

// File: tb/tb_id_stage_hazard.sv
// Self-checking bench for id_stage_hazard: scenario tasks drive IF/ID and
// hazard inputs, push the expected ID/EX contents to a scoreboard queue and
// compare after the clock edge; stall/flush/target are compared in-cycle.
module tb_id_stage_hazard;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [63:0] if_pc;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic        ex_mem_read, ex_reg_write, mem_mem_read;
   logic [4:0]  ex_rd, mem_rd;
   logic        stall, flush;
   logic [63:0] branch_target;
   logic        idex_valid, idex_reg_write, idex_mem_read, idex_mem_write;
   logic        idex_mem_to_reg, idex_alu_src;
   logic [1:0]  idex_alu_op;
   logic [4:0]  idex_rs1, idex_rs2, idex_rd;
   logic [63:0] idex_rdata1, idex_rdata2, idex_imm, idex_link;

   int checks = 0;
   int errors = 0;
   logic [63:0] mregs [32];

   typedef struct packed {
      logic        valid, rw, mr, mw, m2r, as;
      logic [1:0]  aop;
      logic [4:0]  rs1, rs2, rd;
      logic [63:0] d1, d2, imm, link;
   } idex_t;

   idex_t exp_q[$];
   idex_t msk_q[$];

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [7:0]  OP_CBZ  = 8'b10110100;
   localparam logic [7:0]  OP_CBNZ = 8'b10110101;
   localparam logic [5:0]  OP_B    = 6'b000101;
   localparam logic [5:0]  OP_BL   = 6'b100101;

   id_stage_hazard dut (
      .clock(clock), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
      .if_pc(if_pc), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
      .mem_mem_read(mem_mem_read), .mem_rd(mem_rd), .stall(stall), .flush(flush),
      .branch_target(branch_target), .idex_valid(idex_valid),
      .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read),
      .idex_mem_write(idex_mem_write), .idex_mem_to_reg(idex_mem_to_reg),
      .idex_alu_src(idex_alu_src), .idex_alu_op(idex_alu_op),
      .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
      .idex_rdata1(idex_rdata1), .idex_rdata2(idex_rdata2),
      .idex_imm(idex_imm), .idex_link(idex_link)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic idex_t got_idex();
      idex_t g;
      g.valid = idex_valid;   g.rw  = idex_reg_write; g.mr = idex_mem_read;
      g.mw    = idex_mem_write; g.m2r = idex_mem_to_reg; g.as = idex_alu_src;
      g.aop   = idex_alu_op;  g.rs1 = idex_rs1; g.rs2 = idex_rs2; g.rd = idex_rd;
      g.d1    = idex_rdata1;  g.d2  = idex_rdata2; g.imm = idex_imm; g.link = idex_link;
      return g;
   endfunction

   function automatic idex_t mk(logic v, logic rw, logic mr, logic mw, logic m2r,
                                logic as, logic [1:0] aop, logic [4:0] rs1,
                                logic [4:0] rs2, logic [4:0] rd, logic [63:0] d1,
                                logic [63:0] d2, logic [63:0] imm, logic [63:0] link);
      idex_t e;
      e.valid = v; e.rw = rw; e.mr = mr; e.mw = mw; e.m2r = m2r; e.as = as;
      e.aop = aop; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
      e.d1 = d1; e.d2 = d2; e.imm = imm; e.link = link;
      return e;
   endfunction

   // Controls and link are always compared; other fields only when enabled.
   function automatic idex_t mk_mask(bit rd_on, bit s1_on, bit s2_on, bit imm_on);
      idex_t m;
      m = '0;
      m.valid = 1'b1; m.rw = 1'b1; m.mr = 1'b1; m.mw = 1'b1; m.m2r = 1'b1;
      m.as = 1'b1; m.aop = '1; m.link = '1;
      if (rd_on)  m.rd = '1;
      if (s1_on)  begin m.rs1 = '1; m.d1 = '1; end
      if (s2_on)  begin m.rs2 = '1; m.d2 = '1; end
      if (imm_on) m.imm = '1;
      return m;
   endfunction

   function automatic logic [31:0] enc_r(logic [10:0] op, logic [4:0] rm,
                                         logic [4:0] rn, logic [4:0] rd);
      return {op, rm, 6'd0, rn, rd};
   endfunction
   function automatic logic [31:0] enc_d(logic [10:0] op, logic [8:0] imm,
                                         logic [4:0] rn, logic [4:0] rt);
      return {op, imm, 2'b00, rn, rt};
   endfunction
   function automatic logic [31:0] enc_cb(logic [7:0] op, logic [18:0] imm, logic [4:0] rt);
      return {op, imm, rt};
   endfunction
   function automatic logic [31:0] enc_b(logic [5:0] op, logic [25:0] imm);
      return {op, imm};
   endfunction
   function automatic logic [31:0] enc_br(logic [4:0] rn);
      return {11'b11010110000, 5'b11111, 6'd0, rn, 5'd0};
   endfunction

   task automatic clr();
      if_valid = 0; if_instr = 0; if_pc = 0;
      wb_we = 0; wb_rd = 0; wb_data = 0;
      ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0;
      mem_mem_read = 0; mem_rd = 0;
   endtask

   // One clock of the stage: in-cycle checks, then scoreboard check after the edge.
   task automatic cycle(input string name, input logic e_stall, input logic e_flush,
                        input logic [63:0] e_tgt, input idex_t e, input idex_t m);
      idex_t pe, pm, g;
      #2;
      checks++;
      if (stall !== e_stall) begin
         errors++;
         $display("FAIL %s stall: got %b expected %b", name, stall, e_stall);
      end
      checks++;
      if (flush !== e_flush) begin
         errors++;
         $display("FAIL %s flush: got %b expected %b", name, flush, e_flush);
      end
      if (e_flush) begin
         checks++;
         if (branch_target !== e_tgt) begin
            errors++;
            $display("FAIL %s target: got %h expected %h", name, branch_target, e_tgt);
         end
      end
      exp_q.push_back(e);
      msk_q.push_back(m);
      @(posedge clock);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard empty", name);
      end else begin
         pe = exp_q.pop_front();
         pm = msk_q.pop_front();
         g  = got_idex();
         if ((g & pm) !== (pe & pm)) begin
            errors++;
            $display("FAIL %s idex: got %h expected %h", name, g & pm, pe & pm);
         end
      end
   endtask

   task automatic wr(input logic [4:0] idx, input logic [63:0] data);
      clr();
      wb_we = 1; wb_rd = idx; wb_data = data;
      cycle("wr", 0, 0, 0, '0, mk_mask(0, 0, 0, 0));
      if (idx != 5'd31) mregs[idx] = data;
      clr();
   endtask

   task automatic test_reset();
      idex_t g;
      clr();
      if_valid = 1; if_instr = enc_r(OP_ADD, 3, 3, 5);
      ex_mem_read = 1; ex_rd = 3;
      wb_we = 1; wb_rd = 3; wb_data = 64'h55;
      #2;
      checks++;
      if (stall !== 1'b0 || flush !== 1'b0) begin
         errors++;
         $display("FAIL reset_comb: got stall %b flush %b expected 0 0", stall, flush);
      end
      @(posedge clock);
      #1;
      g = got_idex();
      checks++;
      if (g !== '0) begin
         errors++;
         $display("FAIL reset_idex: got %h expected 0", g);
      end
      clr();
      reset = 1;
      for (int i = 0; i < 32; i++) mregs[i] = 0;
      if_valid = 1; if_instr = enc_r(OP_ADD, 3, 3, 5);
      cycle("reset_rf", 0, 0, 0, mk(1,1,0,0,0,0,2'b10,3,3,5,0,0,0,0), mk_mask(1,1,1,0));
   endtask

   task automatic test_write_read();
      wr(3, 64'h10);
      wr(4, 64'h22);
      if_valid = 1; if_instr = enc_r(OP_ADD, 3, 3, 5);
      cycle("add", 0, 0, 0, mk(1,1,0,0,0,0,2'b10,3,3,5,64'h10,64'h10,0,0), mk_mask(1,1,1,0));
      if_instr = enc_r(OP_SUB, 4, 3, 6);
      cycle("sub", 0, 0, 0, mk(1,1,0,0,0,0,2'b10,3,4,6,64'h10,64'h22,0,0), mk_mask(1,1,1,0));
      wb_we = 1; wb_rd = 4; wb_data = 64'h99;
      if_instr = enc_r(OP_ORR, 3, 4, 1);
      cycle("bypass", 0, 0, 0, mk(1,1,0,0,0,0,2'b10,4,3,1,64'h99,64'h10,0,0), mk_mask(1,1,1,0));
      mregs[4] = 64'h99;
      clr(); if_valid = 1;
      if_instr = enc_d(OP_LDUR, 9'h1F8, 3, 9);
      cycle("ldur", 0, 0, 0, mk(1,1,1,0,1,1,2'b00,3,0,9,64'h10,0,-64'sd8,0), mk_mask(1,1,0,1));
      if_instr = enc_d(OP_STUR, 9'd16, 3, 4);
      cycle("stur", 0, 0, 0, mk(1,0,0,1,0,1,2'b00,3,4,0,64'h10,64'h99,64'd16,0), mk_mask(0,1,1,1));
      if_instr = 32'hFFFF_FFFF;
      cycle("nop", 0, 0, 0, mk(1,0,0,0,0,0,2'b00,0,0,0,0,0,0,0), mk_mask(0,0,0,0));
      if_valid = 0; if_instr = enc_r(OP_ADD, 3, 3, 5); ex_mem_read = 1; ex_rd = 3;
      cycle("invalid", 0, 0, 0, '0, mk_mask(0,0,0,0));
      clr();
   endtask

   task automatic test_load_use();
      clr(); if_valid = 1; if_instr = enc_r(OP_ADD, 4, 2, 1);
      ex_mem_read = 1; ex_rd = 2;
      cycle("lu_stall", 1, 0, 0, '0, mk_mask(0,0,0,0));
      ex_mem_read = 0;
      cycle("lu_issue", 0, 0, 0, mk(1,1,0,0,0,0,2'b10,2,4,1,mregs[2],64'h99,0,0), mk_mask(1,1,1,0));
      ex_mem_read = 1; ex_rd = 4;
      cycle("lu_rs2", 1, 0, 0, '0, mk_mask(0,0,0,0));
      if_instr = enc_d(OP_STUR, 9'd16, 3, 4);
      cycle("lu_stur", 1, 0, 0, '0, mk_mask(0,0,0,0));
      if_instr = enc_d(OP_LDUR, 9'd0, 3, 4);
      cycle("lu_dest", 0, 0, 0, mk(1,1,1,0,1,1,2'b00,3,0,4,64'h10,0,0,0), mk_mask(1,1,0,1));
      ex_mem_read = 0; ex_reg_write = 1; ex_rd = 3; if_instr = enc_r(OP_ADD, 3, 3, 5);
      cycle("alu_prod", 0, 0, 0, mk(1,1,0,0,0,0,2'b10,3,3,5,64'h10,64'h10,0,0), mk_mask(1,1,1,0));
      clr();
   endtask

   task automatic test_cbz();
      idex_t vb;
      vb = mk(1,0,0,0,0,0,2'b00,0,0,0,0,0,0,0);
      wr(7, 0);
      if_valid = 1; if_pc = 64'h100; if_instr = enc_cb(OP_CBZ, 19'd4, 7);
      cycle("cbz_taken", 0, 1, 64'h110, vb, mk_mask(0,0,0,0));
      wr(7, 5);
      if_valid = 1; if_pc = 64'h100; if_instr = enc_cb(OP_CBZ, 19'd4, 7);
      cycle("cbz_nt", 0, 0, 0, vb, mk_mask(0,0,0,0));
      if_instr = enc_cb(OP_CBNZ, 19'h7FFFF, 7);
      cycle("cbnz_back", 0, 1, 64'hFC, vb, mk_mask(0,0,0,0));
      if_pc = 64'h300; if_instr = enc_b(OP_B, 26'd8);
      cycle("b", 0, 1, 64'h320, vb, mk_mask(0,0,0,0));
      if_pc = 64'hFFFF_FFFF_FFFF_FFF8; if_instr = enc_cb(OP_CBZ, 19'd4, 31);
      cycle("cb_wrap", 0, 1, 64'h8, vb, mk_mask(0,0,0,0));
      clr();
   endtask

   task automatic test_cb_hazard();
      idex_t vb;
      vb = mk(1,0,0,0,0,0,2'b00,0,0,0,0,0,0,0);
      wr(7, 0);
      if_valid = 1; if_pc = 64'h100; if_instr = enc_cb(OP_CBZ, 19'd4, 7);
      mem_mem_read = 1; mem_rd = 7;
      cycle("cb_mem", 1, 0, 0, '0, mk_mask(0,0,0,0));
      mem_mem_read = 0; ex_reg_write = 1; ex_rd = 7;
      cycle("cb_ex", 1, 0, 0, '0, mk_mask(0,0,0,0));
      ex_reg_write = 0;
      cycle("cb_resolve", 0, 1, 64'h110, vb, mk_mask(0,0,0,0));
      mem_mem_read = 1; mem_rd = 8;
      cycle("cb_other", 0, 1, 64'h110, vb, mk_mask(0,0,0,0));
      wr(9, 64'h4000);
      if_valid = 1; if_pc = 64'h500; if_instr = enc_br(9);
      ex_reg_write = 1; ex_rd = 9;
      cycle("br_stall", 1, 0, 0, '0, mk_mask(0,0,0,0));
      ex_reg_write = 0;
      cycle("br_resolve", 0, 1, 64'h4000, vb, mk_mask(0,0,0,0));
      clr();
   endtask

   task automatic test_xzr();
      wr(31, 64'hDEAD);
      if_valid = 1; if_instr = enc_r(OP_ADD, 31, 31, 1);
      cycle("xzr_read", 0, 0, 0, mk(1,1,0,0,0,0,2'b10,31,31,1,0,0,0,0), mk_mask(1,1,1,0));
      wb_we = 1; wb_rd = 31; wb_data = 64'hBEEF; if_instr = enc_r(OP_ADD, 3, 31, 2);
      cycle("xzr_nobyp", 0, 0, 0, mk(1,1,0,0,0,0,2'b10,31,3,2,0,mregs[3],0,0), mk_mask(1,1,1,0));
      wb_we = 0; ex_mem_read = 1; ex_rd = 31; if_instr = enc_r(OP_ADD, 3, 31, 1);
      cycle("xzr_lu", 0, 0, 0, mk(1,1,0,0,0,0,2'b10,31,3,1,0,mregs[3],0,0), mk_mask(1,1,1,0));
      ex_mem_read = 0; ex_reg_write = 1; mem_mem_read = 1; mem_rd = 31;
      if_pc = 64'h40; if_instr = enc_cb(OP_CBZ, 19'd1, 31);
      cycle("xzr_cb", 0, 1, 64'h44, mk(1,0,0,0,0,0,2'b00,0,0,0,0,0,0,0), mk_mask(0,0,0,0));
      clr();
   endtask

   task automatic test_bl_reset();
      idex_t g;
      if_valid = 1; if_pc = 64'h200; if_instr = enc_b(OP_BL, 26'h3FFFFFF);
`ifdef ID_BL_LINK_EN
      cycle("bl", 0, 1, 64'h1FC, mk(1,1,0,0,0,0,2'b01,0,0,30,0,0,0,64'h204), mk_mask(1,0,0,0));
`else
      cycle("bl", 0, 1, 64'h1FC, mk(1,0,0,0,0,0,2'b00,0,0,0,0,0,0,0), mk_mask(0,0,0,0));
`endif
      clr(); if_valid = 1; if_instr = enc_r(OP_ADD, 3, 3, 5); ex_mem_read = 1; ex_rd = 3;
      #1;
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_stall: got %b expected 1", stall);
      end
      reset = 0;
      #1;
      g = got_idex();
      checks++;
      if (g !== '0 || stall !== 1'b0 || flush !== 1'b0) begin
         errors++;
         $display("FAIL midreset: got idex %h stall %b flush %b expected 0", g, stall, flush);
      end
      @(posedge clock);
      #1;
      reset = 1;
      for (int i = 0; i < 32; i++) mregs[i] = 0;
      clr(); if_valid = 1; if_instr = enc_r(OP_ADD, 3, 3, 5);
      cycle("post_reset", 0, 0, 0, mk(1,1,0,0,0,0,2'b10,3,3,5,0,0,0,0), mk_mask(1,1,1,0));
      clr();
   endtask

   initial begin
      clr();
      for (int i = 0; i < 32; i++) mregs[i] = 0;
      #1;
      test_reset();
      test_write_read();
      test_load_use();
      test_cbz();
      test_cb_hazard();
      test_xzr();
      test_bl_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
